// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit datapath is cut
// into STAGES slices of WIDTH/STAGES bits. Slice k is added in pipeline
// stage k using the carry registered by stage k-1. Operand bits that have
// not been consumed yet travel forward in registers, and finished low sum
// bits travel forward until they leave at the output. Each slice is built
// from 4-bit carry-lookahead groups. Group carries are formed as flat
// generate/propagate sum-of-products, so a carry never ripples from one group
// to the next inside a slice.
//
// Handshake (valid/ready):
//   - An input beat transfers on a rising edge where in_valid && in_ready.
//   - A result transfers on a rising edge where out_valid && out_ready.
//   - enable = !(out_valid && !out_ready). When enable is 0 every pipeline
//     register holds, including the per-stage valid bits, and in_ready is 0.
//   - in_ready is forced to 0 while rst_n is low.
//   - Bubbles move down the pipe as invalid stages and are never collapsed.
//
// A beat accepted on one edge shows up with out_valid=1 after STAGES edges
// with enable high. Each stall cycle adds one more cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat present
//   in_ready   out  beat accepted this cycle
//   A, B       in   WIDTH-bit operands
//   carry_in   in   carry into bit 0 (add mode only)
//   sub        in   1: A - B (A + ~B + 1), 0: A + B + carry_in
//   out_valid  out  result beat present
//   out_ready  in   downstream accepts result
//   S          out  WIDTH-bit sum / difference (registered)
//   carry_out  out  carry out of MSB (subtract: 1 = no borrow)
//   overflow   out  signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW = WIDTH / STAGES;  // slice width
    localparam int NG = (SW + 3) / 4;    // 4-bit lookahead groups per slice
    localparam int PW = NG * 4;          // slice width padded to whole groups

    // Returns the carry into every bit of a slice plus the carry out:
    // c[0] = cin, c[i] = carry into bit i, c[SW] = carry out of the slice.
    // A partial top group is padded with g=0/p=0 bits. The padding sits above
    // every real bit, so it cannot disturb the carries that are used.
    function automatic logic [SW:0] slice_carries(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          cin
    );
        logic [PW-1:0] g;
        logic [PW-1:0] p;
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic [NG:0]   gc;
        logic [PW:0]   c;
        logic          term;
        logic          prod;
        g = '0;
        p = '0;
        g[SW-1:0] = a & b;
        p[SW-1:0] = a ^ b;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        // Group carry j is a flat OR of products:
        // sum over i<j of (G[i] & P[i+1..j-1]), plus (cin & P[0..j-1]).
        gc[0] = cin;
        for (int j = 1; j <= NG; j++) begin
            term = 1'b0;
            for (int i = 0; i < j; i++) begin
                prod = gg[i];
                for (int m = i + 1; m < j; m++) begin
                    prod = prod & gp[m];
                end
                term = term | prod;
            end
            prod = cin;
            for (int m = 0; m < j; m++) begin
                prod = prod & gp[m];
            end
            gc[j] = term | prod;
        end
        // Bit carries inside each group are expanded from that group's carry-in.
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[PW] = gc[NG];
        return c[SW:0];
    endfunction

    logic enable;

    assign enable   = !(out_valid && !out_ready);
    assign in_ready = rst_n && enable;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // x carries {unconsumed A bits, finished sum bits}. y carries the
        // unconsumed B' bits. B' is already inverted for subtraction, so sub
        // is folded into y and the carry and needs no register of its own.
        logic [WIDTH-1:0] x_prev;
        logic [WIDTH-1:0] y_prev;
        logic             c_prev;
        logic             v_prev;
        logic [SW:0]      cv;
        logic [WIDTH-1:0] x_d;
        logic [WIDTH-1:0] x_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_src_in
            assign x_prev = A;
            assign y_prev = sub ? ~B : B;
            assign c_prev = sub | carry_in;   // subtract forces carry-in to 1
            assign v_prev = in_valid;
        end else begin : g_src_prev
            assign x_prev = g_stage[k-1].x_q;
            assign y_prev = g_stage[k-1].g_fwd.y_q;
            assign c_prev = g_stage[k-1].c_q;
            assign v_prev = g_stage[k-1].v_q;
        end

        assign cv = slice_carries(x_prev[k*SW +: SW], y_prev[k*SW +: SW], c_prev);

        always_comb begin
            x_d = x_prev;
            x_d[k*SW +: SW] = x_prev[k*SW +: SW] ^ y_prev[k*SW +: SW] ^ cv[SW-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                x_q <= '0;
            end else if (enable) begin
                v_q <= v_prev;
                c_q <= cv[SW];
                x_q <= x_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] y_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_q <= '0;
                end else if (enable) begin
                    y_q <= y_prev;
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;
            logic unused_y;

            // Only the top slice's B' bits are read here. The rest are
            // already consumed and are tied off through the reduction below.
            assign unused_y = ^y_prev;
            // Carry into the MSB is cv[SW-1]; carry out of the MSB is cv[SW].
            assign ovf_d = cv[SW] ^ cv[SW-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (enable) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign S         = g_stage[STAGES-1].x_q;
    assign carry_out = g_stage[STAGES-1].c_q;
    assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s_o;
    logic             carry_out;
    logic             overflow;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sb;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        vecs[12];
    logic [65:0] exp_q[$];      // {overflow, carry_out, S}
    logic [65:0] cur_exp;
    int          n_cmp  = 0;
    int          n_fail = 0;

    pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_r),
        .B         (b_r),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (s_o),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, expv);
        end
    endtask

    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic sb);
        logic [63:0] bp;
        logic [64:0] r;
        logic        c0;
        logic        ov;
        bp = sb ? ~b : b;
        c0 = sb ? 1'b1 : ci;
        r  = {1'b0, a} + {1'b0, bp} + {64'd0, c0};
        ov = (a[63] == bp[63]) && (r[63] != a[63]);
        return {ov, r[64], r[63:0]};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [65:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got result S=%h with nothing outstanding, required no out_valid", s_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", s_o, e[63:0]);
                    check("carry_out", {63'd0, carry_out}, {63'd0, e[64]});
                    check("overflow", {63'd0, overflow}, {63'd0, e[65]});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one beat starting 1 time unit after a rising edge and returns
    // 1 time unit after the edge that accepted it.
    task automatic drive_beat(input logic [63:0] a, input logic [63:0] b,
                              input logic ci, input logic sb, input logic [65:0] e);
        int   guard;
        logic acc;
        guard    = 0;
        a_r      = a;
        b_r      = b;
        carry_in = ci;
        sub      = sb;
        cur_exp  = e;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", guard);
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Issues one beat from an idle pipe and counts rising edges, the
    // accepting edge included, until out_valid is seen.
    task automatic measure_latency(input string name, input int vi);
        int cnt;
        a_r      = vecs[vi].a;
        b_r      = vecs[vi].b;
        carry_in = vecs[vi].cin;
        sub      = vecs[vi].sb;
        cur_exp  = {vecs[vi].ov, vecs[vi].co, vecs[vi].s};
        in_valid = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            #1 in_valid = 1'b0;
            @(negedge clk);
        end while (!out_valid && cnt < 20);
        check(name, 64'(cnt), 64'(STAGES));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic        rs;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a_r       = '0;
        b_r       = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;

        vecs[0]  = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1]  = '{64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h8000000000000000, 1'b0, 1'b1};
        vecs[2]  = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0};
        vecs[3]  = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
        vecs[4]  = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[5]  = '{64'h5, 64'h5, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[6]  = '{64'h8000000000000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1};
        vecs[7]  = '{64'h00000000FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0000000100000000, 1'b0, 1'b0};
        vecs[8]  = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[9]  = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[11] = '{64'h0000FFFF0000FFFF, 64'h0000000100000001, 1'b0, 1'b0, 64'h0001000000010000, 1'b0, 1'b0};

        // Asynchronous reset with no clock edge yet.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_s", s_o, 64'd0);
        check("rst_carry_out", {63'd0, carry_out}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Latency of a single beat from an idle pipe.
        measure_latency("latency_first", 0);
        drain("drain_latency");

        // Table vectors, back to back.
        for (int i = 0; i < 12; i++) begin
            drive_beat(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb,
                       {vecs[i].ov, vecs[i].co, vecs[i].s});
        end
        in_valid = 1'b0;
        drain("drain_table");

        // 50 random beats with a 3-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    ra = {$urandom(), $urandom()};
                    rb = (i % 7 == 3) ? ~ra : {$urandom(), $urandom()};
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    drive_beat(ra, rb, rc, rs, model(ra, rb, rc, rs));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (20) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_random");

        // Reset in the middle of traffic: three beats go in, one reaches the output.
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            drive_beat(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_valid_before_reset", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("mid_rst_s", s_o, 64'd0);
        check("mid_rst_carry_out", {63'd0, carry_out}, 64'd0);
        check("mid_rst_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("after_rst_idle_valid", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        measure_latency("latency_after_reset", 2);
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
